// File: rtl/perf_ctrl_wb_if.sv
// Wishbone classic bus bundle between the performance-counter controller and its bus master.
interface perf_ctrl_wb_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [7:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/perf_ctrl_wb.sv
// Wishbone slave that opens and closes a measurement window for a bank of 64-bit
// performance counters and exposes their totals as 32-bit word pairs.
module perf_ctrl_wb #(
  parameter int NUM_CNT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  perf_ctrl_wb_if.slave          wb,
  output logic                   perf_start_o,
  output logic                   perf_end_o,
  output logic                   cnt_en_o,
  input  logic [64*NUM_CNT-1:0]  cnt_total_i,
  output logic                   irq_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] cycle_cnt;
  logic [63:0] limit;
  logic        irq_en;
  logic        done;
  logic [31:0] cyc_snap;
  logic [31:0] snap_hi [NUM_CNT];
  logic [63:0] cnt_arr [NUM_CNT];

  logic        access;
  logic        wr;
  logic        rd;
  logic [5:0]  word;
  logic        start_req;
  logic        stop_req;
  logic        clr_done;
  logic        auto_stop;
  logic [31:0] rd_data;
  logic        unused_adr_bits;

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_arr[i] = cnt_total_i[64*i +: 64];
    end
  end

  // A new access is recognised only while no ack is outstanding, so every access
  // takes exactly two cycles and side effects fire on the cycle that produces the ack.
  assign access    = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign wr        = access & wb.wb_we_i;
  assign rd        = access & ~wb.wb_we_i;
  assign word      = wb.wb_adr_i[7:2];
  assign unused_adr_bits = ^wb.wb_adr_i[1:0];

  assign start_req = wr && (word == 6'd0) && wb.wb_dat_i[0];
  assign stop_req  = wr && (word == 6'd0) && wb.wb_dat_i[1];
  assign clr_done  = wr && (word == 6'd1) && wb.wb_dat_i[2];
  assign auto_stop = (limit != 64'd0) && ((cycle_cnt + 64'd1) == limit);
  assign irq_o     = done & irq_en;

  always_comb begin
    rd_data = 32'd0;
    case (word)
      6'd0: rd_data = {29'd0, irq_en, 2'b00};
      6'd1: rd_data = {29'd0, done, state};
      6'd2: rd_data = limit[31:0];
      6'd3: rd_data = limit[63:32];
      6'd4: rd_data = cycle_cnt[31:0];
      6'd5: rd_data = cyc_snap;
      default: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (word == 6'(8 + 2*i)) rd_data = cnt_arr[i][31:0];
          if (word == 6'(9 + 2*i)) rd_data = snap_hi[i];
        end
      end
    endcase
  end

  // Bus side: ack/data, software-visible configuration and the high-word snapshots.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= 32'd0;
      irq_en      <= 1'b0;
      limit       <= 64'd0;
      cyc_snap    <= 32'd0;
      for (int i = 0; i < NUM_CNT; i++) snap_hi[i] <= 32'd0;
    end else begin
      wb.wb_ack_o <= access;
      wb.wb_dat_o <= rd ? rd_data : 32'd0;
      if (wr) begin
        case (word)
          6'd0:    irq_en        <= wb.wb_dat_i[2];
          6'd2:    limit[31:0]   <= wb.wb_dat_i;
          6'd3:    limit[63:32]  <= wb.wb_dat_i;
          default: ;
        endcase
      end
      if (rd) begin
        if (word == 6'd4) cyc_snap <= cycle_cnt[63:32];
        for (int i = 0; i < NUM_CNT; i++) begin
          if (word == 6'(8 + 2*i)) snap_hi[i] <= cnt_arr[i][63:32];
        end
      end
    end
  end

  // START restarts the window from any state and beats STOP/auto-stop; the single
  // SETTLE cycle lets the counters register their totals after perf_end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cycle_cnt    <= 64'd0;
      done         <= 1'b0;
      perf_start_o <= 1'b0;
      perf_end_o   <= 1'b0;
      cnt_en_o     <= 1'b0;
    end else begin
      perf_start_o <= 1'b0;
      perf_end_o   <= 1'b0;
      if (clr_done) done <= 1'b0;
      if (start_req) begin
        state        <= S_RUN;
        cycle_cnt    <= 64'd0;
        perf_start_o <= 1'b1;
        cnt_en_o     <= 1'b1;
        done         <= 1'b0;
      end else begin
        case (state)
          S_RUN: begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (stop_req || auto_stop) begin
              perf_end_o <= 1'b1;
              cnt_en_o   <= 1'b0;
              state      <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            state <= S_DONE;
            done  <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_perf_ctrl_wb.sv
// Randomised scoreboard bench for perf_ctrl_wb; expectations come from a timestamp model
// of the measurement window rather than a cycle-by-cycle state machine.
module tb_perf_ctrl_wb;
  localparam int NUM_CNT = 4;
  localparam longint unsigned INF = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic perf_start_o, perf_end_o, cnt_en_o, irq_o;
  logic [64*NUM_CNT-1:0] cnt_total = '0;

  perf_ctrl_wb_if wb ();

  perf_ctrl_wb #(.NUM_CNT(NUM_CNT)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb           (wb),
    .perf_start_o (perf_start_o),
    .perf_end_o   (perf_end_o),
    .cnt_en_o     (cnt_en_o),
    .cnt_total_i  (cnt_total),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  longint unsigned now = 0;
  always @(posedge clk) now <= now + 1;

  int n_checks = 0;
  int n_fail = 0;
  bit checking = 1'b0;
  int n_start_seen = 0, n_end_seen = 0, n_en_seen = 0;
  exp_t exp_q[$];

  // Window model: a run is described by the cycle it began and the cycle of its last RUN cycle.
  bit              m_started;
  longint unsigned m_origin, m_end, m_clr;
  logic [63:0]     m_limit;
  bit              m_irq_en;
  logic [31:0]     m_snap [NUM_CNT];
  logic [31:0]     m_cyc_snap;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, now);
    end
  endtask

  function automatic void model_reset();
    m_started  = 1'b0;
    m_origin   = 0;
    m_end      = INF;
    m_clr      = 0;
    m_limit    = 64'd0;
    m_irq_en   = 1'b0;
    m_cyc_snap = 32'd0;
    for (int i = 0; i < NUM_CNT; i++) m_snap[i] = 32'd0;
  endfunction

  function automatic int phase_at(longint unsigned c);
    if (!m_started) return 0;
    if (m_end == INF || c <= m_end) return 1;
    if (c == m_end + 1) return 2;
    return 3;
  endfunction

  function automatic logic [63:0] cyc_at(longint unsigned c);
    if (!m_started) return 64'd0;
    if (phase_at(c) == 1) return c - m_origin;
    return m_end - m_origin + 1;
  endfunction

  function automatic bit done_at(longint unsigned c);
    if (!m_started || m_end == INF) return 1'b0;
    if (c < m_end + 2) return 1'b0;
    return !(m_clr >= m_end + 2 && m_clr < c);
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] adr, input longint unsigned a);
    int w;
    int i;
    logic [63:0] v;
    w = int'(adr[7:2]);
    case (w)
      0: return {29'd0, m_irq_en, 2'b00};
      1: return {29'd0, done_at(a), 2'(phase_at(a))};
      2: return m_limit[31:0];
      3: return m_limit[63:32];
      4: begin
        v = cyc_at(a);
        m_cyc_snap = v[63:32];
        return v[31:0];
      end
      5: return m_cyc_snap;
      default: begin
        if (w >= 8 && w < 8 + 2*NUM_CNT) begin
          i = (w - 8) / 2;
          if (w % 2 == 0) begin
            m_snap[i] = cnt_total[64*i+32 +: 32];
            return cnt_total[64*i +: 32];
          end
          return m_snap[i];
        end
        return 32'd0;
      end
    endcase
  endfunction

  function automatic void model_write(input logic [7:0] adr, input logic [31:0] dat, input longint unsigned a);
    case (int'(adr[7:2]))
      0: begin
        m_irq_en = dat[2];
        if (dat[0]) begin
          m_started = 1'b1;
          m_origin  = a + 1;
          m_end     = (m_limit != 64'd0) ? m_origin + m_limit - 1 : INF;
        end else if (dat[1] && phase_at(a) == 1) begin
          m_end = a;
        end
      end
      1: if (dat[2]) m_clr = a;
      2: m_limit[31:0]  = dat;
      3: m_limit[63:32] = dat;
      default: ;
    endcase
  endfunction

  task automatic applyStimulus(input bit we, input logic [7:0] adr, input logic [31:0] dat);
    longint unsigned a;
    exp_t e;
    @(negedge clk);
    a = now;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    e.is_read = !we;
    e.data    = we ? 32'd0 : model_read(adr, a);
    exp_q.push_back(e);
    checkOutput("ack_not_early", {63'd0, wb.wb_ack_o}, 64'd0);
    @(posedge clk);
    if (we) model_write(adr, dat, a);
    @(negedge clk);
    checkOutput("ack_latency", {63'd0, wb.wb_ack_o}, 64'd1);
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: per-cycle pulse/enable/irq checks and scoreboard pops on every ack.
  always @(negedge clk) begin
    exp_t e;
    if (checking && !rst) begin
      checkOutput("perf_start", {63'd0, perf_start_o}, {63'd0, m_started && now == m_origin});
      checkOutput("perf_end", {63'd0, perf_end_o}, {63'd0, m_started && m_end != INF && now == m_end + 1});
      checkOutput("cnt_en", {63'd0, cnt_en_o}, {63'd0, phase_at(now) == 1});
      checkOutput("irq", {63'd0, irq_o}, {63'd0, done_at(now) && m_irq_en});
      if (perf_start_o) n_start_seen++;
      if (perf_end_o) n_end_seen++;
      if (cnt_en_o) n_en_seen++;
      if (wb.wb_ack_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_ack", {63'd0, wb.wb_ack_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_read) checkOutput("rdata", {32'd0, wb.wb_dat_o}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bs, be, ben, op;
    logic [7:0] adr;
    logic [31:0] dat;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = 8'd0;
    wb.wb_dat_i = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("reset_ack", {63'd0, wb.wb_ack_o}, 64'd0);
    checkOutput("reset_dat", {32'd0, wb.wb_dat_o}, 64'd0);
    applyStimulus(1'b0, 8'h04, 32'd0);
    applyStimulus(1'b0, 8'h20, 32'd0);

    // Auto-stop window with limit 100 and interrupt enabled
    applyStimulus(1'b1, 8'h08, 32'd100);
    applyStimulus(1'b1, 8'h0C, 32'd0);
    bs = n_start_seen; be = n_end_seen; ben = n_en_seen;
    applyStimulus(1'b1, 8'h00, 32'h5);
    repeat (110) @(negedge clk);
    checkOutput("limit_start_pulses", 64'(n_start_seen - bs), 64'd1);
    checkOutput("limit_end_pulses", 64'(n_end_seen - be), 64'd1);
    checkOutput("limit_en_cycles", 64'(n_en_seen - ben), 64'd100);
    checkOutput("limit_irq", {63'd0, irq_o}, 64'd1);
    applyStimulus(1'b0, 8'h04, 32'd0);
    applyStimulus(1'b0, 8'h10, 32'd0);

    // High-word snapshot survives an input change between LO and HI reads
    cnt_total[63:0] = 64'h0000_0002_FFFF_FFF0;
    applyStimulus(1'b0, 8'h20, 32'd0);
    cnt_total[63:0] = 64'h0000_0003_0000_0000;
    applyStimulus(1'b0, 8'h24, 32'd0);

    // Open-ended window closed by software STOP
    applyStimulus(1'b1, 8'h08, 32'd0);
    ben = n_en_seen; be = n_end_seen;
    applyStimulus(1'b1, 8'h00, 32'h1);
    repeat (50) @(negedge clk);
    applyStimulus(1'b1, 8'h00, 32'h2);
    repeat (5) @(negedge clk);
    checkOutput("stop_end_pulses", 64'(n_end_seen - be), 64'd1);
    checkOutput("stop_en_vs_cyc", 64'(n_en_seen - ben), cyc_at(now));
    applyStimulus(1'b0, 8'h10, 32'd0);

    // START+STOP while running restarts without perf_end
    applyStimulus(1'b1, 8'h00, 32'h1);
    repeat (10) @(negedge clk);
    bs = n_start_seen; be = n_end_seen;
    applyStimulus(1'b1, 8'h00, 32'h3);
    repeat (5) @(negedge clk);
    checkOutput("restart_start_pulses", 64'(n_start_seen - bs), 64'd1);
    checkOutput("restart_end_pulses", 64'(n_end_seen - be), 64'd0);
    applyStimulus(1'b0, 8'h10, 32'd0);

    // Reset mid-run, then STOP in IDLE does nothing
    pulseReset();
    bs = n_start_seen; be = n_end_seen;
    applyStimulus(1'b1, 8'h00, 32'h2);
    repeat (5) @(negedge clk);
    checkOutput("idle_stop_start", 64'(n_start_seen - bs), 64'd0);
    checkOutput("idle_stop_end", 64'(n_end_seen - be), 64'd0);
    applyStimulus(1'b0, 8'h04, 32'd0);

    // Unmapped read and done W1C
    applyStimulus(1'b0, 8'h60, 32'd0);
    applyStimulus(1'b1, 8'h08, 32'd5);
    applyStimulus(1'b1, 8'h00, 32'h5);
    repeat (10) @(negedge clk);
    checkOutput("done_irq_set", {63'd0, irq_o}, 64'd1);
    applyStimulus(1'b1, 8'h04, 32'h4);
    checkOutput("done_irq_clear", {63'd0, irq_o}, 64'd0);
    applyStimulus(1'b0, 8'h04, 32'd0);

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        adr = 8'($urandom_range(0, 127));
        applyStimulus(1'b0, adr, 32'd0);
      end else if (op == 4) begin
        dat = 32'($urandom_range(0, 7));
        applyStimulus(1'b1, 8'h00, dat);
      end else if (op == 5) begin
        adr = 8'($urandom_range(0, 127));
        dat = $urandom;
        if (phase_at(now) == 1 && (adr[7:2] == 6'd2 || adr[7:2] == 6'd3))
          applyStimulus(1'b0, adr, 32'd0);
        else
          applyStimulus(1'b1, adr, dat);
      end else if (op == 6) begin
        if (phase_at(now) != 1) begin
          applyStimulus(1'b1, 8'h08, 32'($urandom_range(0, 30)));
          applyStimulus(1'b1, 8'h0C, ($urandom_range(0, 9) == 0) ? 32'd1 : 32'd0);
        end else begin
          applyStimulus(1'b0, 8'h10, 32'd0);
        end
      end else if (op == 7) begin
        repeat ($urandom_range(1, 15)) @(negedge clk);
      end else if (op == 8) begin
        cnt_total[64*$urandom_range(0, NUM_CNT-1) +: 64] = {$urandom, $urandom};
      end else begin
        if ($urandom_range(0, 9) == 0) pulseReset();
        else applyStimulus(1'b0, 8'h04, 32'd0);
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
